// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared constants, mode encoding and tile truncation rule
// for the approximate multiplier pipeline.
package approx_mult_pkg;

  localparam int TILE_W = 4;

  typedef enum logic [1:0] {
    MODE_EXACT    = 2'd0,
    MODE_LOWTRUNC = 2'd1,
    MODE_AGGR     = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // LSBs dropped from tile (i,j) of an n-digit operand pair under a mode.
  // The reserved mode computes exactly; it is only flagged downstream.
  function automatic logic [1:0] tile_k(input mode_e mode, input int i,
                                        input int j, input int n);
    logic [1:0] k;
    k = 2'd0;
    case (mode)
      MODE_LOWTRUNC: k = (i + j < n - 1) ? 2'd3 : 2'd0;
      MODE_AGGR:     k = (i == n - 1 && j == n - 1) ? 2'd1 : 2'd3;
      default:       k = 2'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_tile.sv
// approx_tile_4x4: one 4x4 digit product with its low k bits cleared.
module approx_tile_4x4
  import approx_mult_pkg::*;
(
  input  logic [TILE_W-1:0]   a,
  input  logic [TILE_W-1:0]   b,
  input  logic [1:0]          k,
  output logic [2*TILE_W-1:0] p
);

  logic [2*TILE_W-1:0] w_full;

  assign w_full = {{TILE_W{1'b0}}, a} * {{TILE_W{1'b0}}, b};
  assign p      = w_full & ({(2*TILE_W){1'b1}} << k);

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage tiled approximate multiplier with valid/ready
// handshake and a global stall. S1 captures operands, S2 registers the
// truncated tile products, S3 registers the weighted sum.
// Optional feature macro: APPROX_MULT_STATS_EN enables the saturating
// counter of accepted approximate (mode 1/2) beats on stat_cnt.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r,
  output logic               mode_err,
  output logic [31:0]        stat_cnt
);

  localparam int N  = WIDTH / TILE_W;
  localparam int NT = N * N;
  localparam int RW = 2 * WIDTH;

  logic [STAGES:1]            r_vld_pipe;
  logic                       w_stall;
  logic                       w_acc;
  logic [WIDTH-1:0]           r_a;
  logic [WIDTH-1:0]           r_b;
  logic [1:0]                 r_mode;
  logic [NT-1:0][2*TILE_W-1:0] w_tile;
  logic [NT-1:0][2*TILE_W-1:0] r_tile;
  logic                       r_err2;
  logic [RW-1:0]              w_sum;

  // A result sitting unaccepted at the output freezes the whole pipe.
  assign w_stall   = r_vld_pipe[STAGES] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_acc     = in_valid & in_ready;
  assign out_valid = r_vld_pipe[STAGES];

  for (genvar gi = 0; gi < N; gi++) begin : g_i
    for (genvar gj = 0; gj < N; gj++) begin : g_j
      logic [1:0] w_k;
      assign w_k = tile_k(mode_e'(r_mode), gi, gj, N);
      approx_tile_4x4 u_tile (
        .a (r_a[gi*TILE_W +: TILE_W]),
        .b (r_b[gj*TILE_W +: TILE_W]),
        .k (w_k),
        .p (w_tile[gi*N + gj])
      );
    end
  end

  // Weight each registered tile by its digit position and accumulate.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w_sum = w_sum + (RW'(r_tile[i*N + j]) << (TILE_W * (i + j)));
  end

  // Stage registers; data only moves with a valid beat so bubbles keep r steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= '0;
      r_tile     <= '0;
      r_err2     <= 1'b0;
      r          <= '0;
      mode_err   <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
      if (w_acc) begin
        r_a    <= a;
        r_b    <= b;
        r_mode <= mode;
      end
      if (r_vld_pipe[1]) begin
        r_tile <= w_tile;
        r_err2 <= (r_mode == MODE_RSVD);
      end
      if (r_vld_pipe[2]) begin
        r        <= w_sum;
        mode_err <= r_err2;
      end
    end
  end

`ifdef APPROX_MULT_STATS_EN
  logic [31:0] r_stat;

  // Count accepted approximate beats, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stat <= '0;
    else if (w_acc && (mode == MODE_LOWTRUNC || mode == MODE_AGGR) &&
             r_stat != 32'hFFFF_FFFF)
      r_stat <= r_stat + 32'd1;
  end

  assign stat_cnt = r_stat;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: self-checking bench for an 8-bit and a 16-bit instance.
module tb_approx_mult_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, or8 = 1'b1, ir8, ov8, err8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  m8 = '0;
  logic [15:0] r8;
  logic [31:0] st8;

  logic        iv16 = 1'b0, or16 = 1'b1, ir16, ov16, err16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [1:0]  m16 = '0;
  logic [31:0] r16;
  logic [31:0] st16;

`ifdef APPROX_MULT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [31:0] r;
    logic        err;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  approx_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .mode(m8), .out_valid(ov8), .out_ready(or8), .r(r8), .mode_err(err8),
    .stat_cnt(st8)
  );

  approx_mult_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .mode(m16), .out_valid(ov16), .out_ready(or16), .r(r16), .mode_err(err16),
    .stat_cnt(st16)
  );

  // Reference: exact product minus the low bits each tile loses.
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] m, input int n);
    logic [31:0] p;
    logic [7:0]  t;
    int          kk;
    p = 32'(a) * 32'(b);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        t = {4'b0, a[4*i +: 4]} * {4'b0, b[4*j +: 4]};
        if (m == 2'd1)      kk = (i + j < n - 1) ? 3 : 0;
        else if (m == 2'd2) kk = (i == n - 1 && j == n - 1) ? 1 : 3;
        else                kk = 0;
        p = p - ((32'(t) & ((32'd1 << kk) - 32'd1)) << (4 * (i + j)));
      end
    return p;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (ir8 !== 1'b1)   $display("FAIL reset_in_ready: got %b want 1", ir8); else n_pass++;
    n_chk++; if (ov8 !== 1'b0)   $display("FAIL reset_out_valid: got %b want 0", ov8); else n_pass++;
    n_chk++; if (r8 !== 16'h0)   $display("FAIL reset_r: got %h want 0000", r8); else n_pass++;
    n_chk++; if (err8 !== 1'b0)  $display("FAIL reset_mode_err: got %b want 0", err8); else n_pass++;
    n_chk++; if (st8 !== 32'h0)  $display("FAIL reset_stat: got %h want 0", st8); else n_pass++;
    n_chk++; if (ov16 !== 1'b0 || err16 !== 1'b0 || st16 !== 32'h0)
      $display("FAIL reset_w16: got ov=%b err=%b st=%h want 0/0/0", ov16, err16, st16);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact();
    @(negedge clk); or8 = 1'b1; iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; m8 = 2'd0;
    @(posedge clk);
    @(negedge clk); iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    n_chk++; if (ov8 !== 1'b0) $display("FAIL exact_lat1: out_valid got %b want 0", ov8); else n_pass++;
    @(negedge clk);
    n_chk++; if (ov8 !== 1'b0) $display("FAIL exact_lat2: out_valid got %b want 0", ov8); else n_pass++;
    @(negedge clk);
    n_chk++; if (ov8 !== 1'b1) $display("FAIL exact_lat3: out_valid got %b want 1", ov8); else n_pass++;
    n_chk++; if (r8 !== 16'hFE01) $display("FAIL exact_r: got %h want fe01", r8); else n_pass++;
    n_chk++; if (err8 !== 1'b0) $display("FAIL exact_err: got %b want 0", err8); else n_pass++;
    @(negedge clk);
    n_chk++; if (ov8 !== 1'b0) $display("FAIL exact_single: out_valid got %b want 0", ov8); else n_pass++;
  endtask

  task automatic test_modes();
    logic [7:0]  ta [3] = '{8'hFF, 8'hFF, 8'h12};
    logic [7:0]  tb [3] = '{8'hFF, 8'hFF, 8'h34};
    logic [1:0]  tm [3] = '{2'd1, 2'd2, 2'd3};
    logic [15:0] tr [3] = '{16'hFE00, 16'hFCE0, 16'h03A8};
    logic [31:0] s0;
    exp_t        e;
    s0 = st8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); iv8 = 1'b1; a8 = ta[k]; b8 = tb[k]; m8 = tm[k];
      sb8.push_back('{r: 32'(tr[k]), err: (k == 2)});
    end
    for (int c = 0; c < 12 && sb8.size() > 0; c++) begin
      @(negedge clk); iv8 = 1'b0;
      if (ov8) begin
        e = sb8.pop_front();
        n_chk++; if (r8 !== e.r[15:0]) $display("FAIL modes_r: got %h want %h", r8, e.r[15:0]); else n_pass++;
        n_chk++; if (err8 !== e.err) $display("FAIL modes_err: got %b want %b", err8, e.err); else n_pass++;
      end
    end
    n_chk++; if (sb8.size() != 0) begin $display("FAIL modes_timeout: %0d results missing want 0", sb8.size()); sb8.delete(); end else n_pass++;
    n_chk++; if (st8 !== s0 + (STATS ? 32'd2 : 32'd0))
      $display("FAIL modes_stat: got %0d want %0d", st8, s0 + (STATS ? 32'd2 : 32'd0));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta [8];
    logic [7:0]  tb [8];
    logic [1:0]  tm [8];
    logic [15:0] held = '0;
    int          idx = 0, stall_left = -1;
    exp_t        e;
    for (int k = 0; k < 8; k++) begin
      ta[k] = 8'($urandom); tb[k] = 8'($urandom); tm[k] = 2'($urandom_range(3));
    end
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (stall_left < 0 && ov8) stall_left = 5;
      or8 = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        if (stall_left == 5) held = r8;
        else begin
          n_chk++; if (r8 !== held) $display("FAIL b2b_hold_r: got %h want %h", r8, held); else n_pass++;
        end
        n_chk++; if (ir8 !== 1'b0) $display("FAIL b2b_in_ready: got %b want 0", ir8); else n_pass++;
        n_chk++; if (ov8 !== 1'b1) $display("FAIL b2b_hold_valid: got %b want 1", ov8); else n_pass++;
        stall_left--;
      end else if (ov8) begin
        n_chk++;
        if (sb8.size() == 0) $display("FAIL b2b_extra: got result %h want none", r8);
        else begin
          e = sb8.pop_front();
          if (r8 !== e.r[15:0] || err8 !== e.err)
            $display("FAIL b2b_result: got %h/%b want %h/%b", r8, err8, e.r[15:0], e.err);
          else n_pass++;
        end
      end
      if (idx < 8) begin
        iv8 = 1'b1; a8 = ta[idx]; b8 = tb[idx]; m8 = tm[idx];
        if (ir8) begin
          sb8.push_back('{r: ref_prod(16'(ta[idx]), 16'(tb[idx]), tm[idx], 2), err: (tm[idx] == 2'd3)});
          idx++;
        end
      end else begin
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 2'($urandom_range(3));
      end
      if (idx == 8 && sb8.size() == 0 && stall_left == 0) break;
    end
    n_chk++;
    if (idx != 8 || sb8.size() != 0 || stall_left != 0) begin
      $display("FAIL b2b_timeout: sent %0d pending %0d stall %0d want 8/0/0", idx, sb8.size(), stall_left);
      sb8.delete();
    end else n_pass++;
    or8 = 1'b1; iv8 = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (ov8 !== 1'b0) $display("FAIL b2b_dup: out_valid got %b want 0", ov8); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] s0;
    s0 = st8;
    or8 = 1'b0;
    @(negedge clk); iv8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; m8 = 2'd1;
    @(negedge clk); a8 = 8'h77; b8 = 8'h19; m8 = 2'd2;
    @(negedge clk); iv8 = 1'b0;
    @(negedge clk);
    n_chk++; if (ov8 !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", ov8); else n_pass++;
    n_chk++; if (st8 !== s0 + (STATS ? 32'd2 : 32'd0))
      $display("FAIL rstmid_pre_stat: got %0d want %0d", st8, s0 + (STATS ? 32'd2 : 32'd0));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (ov8 !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", ov8); else n_pass++;
    n_chk++; if (st8 !== 32'h0) $display("FAIL rstmid_stat: got %0d want 0", st8); else n_pass++;
    n_chk++; if (ir8 !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", ir8); else n_pass++;
    @(negedge clk); rst_n = 1'b1; or8 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++; if (ov8 !== 1'b0) $display("FAIL rstmid_stale: cycle %0d out_valid got %b want 0", c, ov8); else n_pass++;
    end
  endtask

  task automatic test_random16();
    int   sent = 0, got = 0;
    exp_t e;
    for (int c = 0; c < 30000 && got < 10000; c++) begin
      @(negedge clk);
      or16 = ($urandom_range(7) != 0);
      #1;
      if (ov16 && or16) begin
        n_chk++;
        if (sb16.size() == 0) $display("FAIL rand16_extra: got %h want none", r16);
        else begin
          e = sb16.pop_front();
          if (r16 !== e.r || err16 !== 1'b0)
            $display("FAIL rand16_r: beat %0d got %h/%b want %h/0", got, r16, err16, e.r);
          else n_pass++;
        end
        got++;
      end
      if (sent < 10000) begin
        iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); m16 = 2'd0;
        if (ir16) begin
          sb16.push_back('{r: 32'(a16) * 32'(b16), err: 1'b0});
          sent++;
        end
      end else iv16 = 1'b0;
    end
    iv16 = 1'b0; or16 = 1'b1;
    n_chk++; if (got != 10000 || sb16.size() != 0)
      $display("FAIL rand16_count: got %0d results pending %0d want 10000/0", got, sb16.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_modes();
    test_back_to_back();
    test_reset_midflight();
    test_random16();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
